mips_fetch_stage: RTL and testbench

IF stage of the 5-stage pipelined MIPS core. It holds the PC, forms the next PC from sequential, branch and jump sources, and addresses the combinational instruction memory. It owns the IF/ID pipeline register that feeds the decode stage (Instr_D, PC+4), and it obeys stall and flush controls from the hazard unit. It also traps illegal fetch addresses and keeps fetch/stall performance counters.

---
 rtl/mips_fetch_stage.sv | 100 ++++++++++
 tb/tb_mips_fetch_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection,
// IF/ID pipeline register, illegal-fetch trap and fetch/stall counters.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_f,
  input  logic                          stall_d,
  input  logic                          flush_d,
  input  logic                          pc_src_d,
  input  logic [31:0]                   pc_branch_d,
  input  logic                          jump_d,
  input  logic [31:0]                   jump_target_d,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  output logic [31:0]                   pc_f,
  output logic [31:0]                   instr_d,
  output logic [31:0]                   pc_plus4_d,
  output logic                          valid_d,
  output logic                          fetch_fault,
  output logic [CNT_W-1:0]              fetch_count,
  output logic [CNT_W-1:0]              stall_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state;
  logic        illegal_pc_c;
  logic [31:0] pc_plus4_c;
  logic [31:0] pc_next_c;

  // Word index into the instruction memory; low two bits are the byte offset.
  assign imem_addr  = pc_f[AW+1:2];
  assign pc_plus4_c = pc_f + 32'd4;

  // Misaligned, or beyond the last word of instruction memory.
  assign illegal_pc_c = (pc_f[1:0] != 2'b00) || ((pc_f >> (AW + 2)) != 32'd0);

  // Next-PC selection; stalled redirects are dropped and re-presented later.
  always_comb begin
    pc_next_c = pc_f;
    if (state == RUN && !illegal_pc_c && !stall_f) begin
      if (jump_d)        pc_next_c = jump_target_d;
      else if (pc_src_d) pc_next_c = pc_branch_d;
      else               pc_next_c = pc_plus4_c;
    end
  end

  // State, PC, IF/ID register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_f        <= RESET_PC;
      instr_d     <= 32'd0;
      pc_plus4_d  <= 32'd0;
      valid_d     <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      pc_f <= pc_next_c;
      if (state == RUN) begin
        if (illegal_pc_c) begin
          state       <= FAULT;
          fetch_fault <= 1'b1;
        end
        if (stall_f && (stall_count != {CNT_W{1'b1}})) begin
          stall_count <= stall_count + CNT_W'(1);
        end
        if (flush_d || (!stall_d && illegal_pc_c)) begin
          instr_d    <= 32'd0;
          pc_plus4_d <= 32'd0;
          valid_d    <= 1'b0;
        end else if (!stall_d) begin
          instr_d    <= imem_rdata;
          pc_plus4_d <= pc_plus4_c;
          valid_d    <= 1'b1;
          if (fetch_count != {CNT_W{1'b1}}) begin
            fetch_count <= fetch_count + CNT_W'(1);
          end
        end
      end else begin
        // Trapped: only reset leaves FAULT, decode sees bubbles.
        fetch_fault <= 1'b1;
        instr_d     <= 32'd0;
        pc_plus4_d  <= 32'd0;
        valid_d     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: expected IF-stage snapshots are
// queued as stimulus is driven and compared one edge later.
module tb_mips_fetch_stage;

  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
  logic          pc_src_d = 1'b0, jump_d = 1'b0;
  logic [31:0]   pc_branch_d = 32'd0, jump_target_d = 32'd0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   pc_f, instr_d, pc_plus4_d;
  logic          valid_d, fetch_fault;
  logic [31:0]   fetch_count, stall_count;

  int    n_checks = 0;
  int    n_pass   = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x2000_0000 + k.
  assign imem_rdata = 32'h2000_0000 | 32'(imem_addr);

  mips_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
    .jump_d(jump_d), .jump_target_d(jump_target_d), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  function automatic snap_t snap();
    return '{pc: pc_f, instr: instr_d, pc4: pc_plus4_d, valid: valid_d, fault: fetch_fault};
  endfunction

  function automatic snap_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic v, input logic f);
    return '{pc: pc, instr: instr, pc4: pc4, valid: v, fault: f};
  endfunction

  task automatic clear_inputs();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_d = 1'b0; jump_d = 1'b0; pc_branch_d = 32'd0; jump_target_d = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, g;
    rst_n = 1'b0;
    clear_inputs();
    exp_q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    #3;
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL reset_state got %h exp %h", g, e); else n_pass++;
    n_checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0)
      $display("FAIL reset_counters got %0d/%0d exp 0/0", fetch_count, stall_count);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 8'd0) $display("FAIL reset_imem_addr got %h exp 00", imem_addr); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    snap_t e, g;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(32'(4 * k), 32'h2000_0000 + 32'(k - 1), 32'(4 * k), 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); g = snap();
      n_checks++;
      if (g !== e) $display("FAIL seq_edge%0d got %h exp %h", k, g, e); else n_pass++;
    end
    n_checks++;
    if (fetch_count !== 32'd4) $display("FAIL seq_fetch_count got %0d exp 4", fetch_count); else n_pass++;
    n_checks++;
    if (imem_addr !== 8'd4) $display("FAIL seq_imem_addr got %h exp 04", imem_addr); else n_pass++;
  endtask

  task automatic test_stall();
    snap_t e, g;
    stall_f = 1'b1; stall_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(32'h10, 32'h2000_0003, 32'h10, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); g = snap();
      n_checks++;
      if (g !== e) $display("FAIL stall_hold%0d got %h exp %h", k, g, e); else n_pass++;
    end
    n_checks++;
    if (stall_count !== 32'd3 || fetch_count !== 32'd4)
      $display("FAIL stall_counts got %0d/%0d exp 3/4", stall_count, fetch_count);
    else n_pass++;
    clear_inputs();
    exp_q.push_back(mk(32'h14, 32'h2000_0004, 32'h14, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL stall_release got %h exp %h", g, e); else n_pass++;
  endtask

  task automatic test_branch();
    snap_t e, g;
    pc_src_d = 1'b1; pc_branch_d = 32'h40; flush_d = 1'b1;
    exp_q.push_back(mk(32'h40, 32'd0, 32'd0, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL branch_flush got %h exp %h", g, e); else n_pass++;
    clear_inputs();
    exp_q.push_back(mk(32'h44, 32'h2000_0010, 32'h44, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL branch_target_fetch got %h exp %h", g, e); else n_pass++;
    n_checks++;
    if (fetch_count !== 32'd6) $display("FAIL branch_fetch_count got %0d exp 6", fetch_count); else n_pass++;
  endtask

  task automatic test_jump_priority();
    snap_t e, g;
    jump_d = 1'b1; jump_target_d = 32'h80; pc_src_d = 1'b1; pc_branch_d = 32'h40;
    exp_q.push_back(mk(32'h80, 32'h2000_0011, 32'h48, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL jump_wins got %h exp %h", g, e); else n_pass++;
    clear_inputs();
    flush_d = 1'b1; stall_d = 1'b1;
    exp_q.push_back(mk(32'h84, 32'd0, 32'd0, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL flush_over_stall got %h exp %h", g, e); else n_pass++;
    clear_inputs();
    exp_q.push_back(mk(32'h88, 32'h2000_0021, 32'h88, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL after_bubble got %h exp %h", g, e); else n_pass++;
  endtask

  task automatic test_misaligned_fault();
    snap_t e, g;
    jump_d = 1'b1; jump_target_d = 32'h402;
    exp_q.push_back(mk(32'h402, 32'h2000_0022, 32'h8C, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL misaligned_load got %h exp %h", g, e); else n_pass++;
    clear_inputs();
    exp_q.push_back(mk(32'h402, 32'd0, 32'd0, 1'b0, 1'b1));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL misaligned_trap got %h exp %h", g, e); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      flush_d = k[0]; stall_d = ~k[0]; stall_f = 1'b1;
      jump_d = 1'b1; jump_target_d = 32'h0;
      exp_q.push_back(mk(32'h402, 32'd0, 32'd0, 1'b0, 1'b1));
      tick();
      e = exp_q.pop_front(); g = snap();
      n_checks++;
      if (g !== e) $display("FAIL fault_sticky%0d got %h exp %h", k, g, e); else n_pass++;
    end
    clear_inputs();
    n_checks++;
    if (stall_count !== 32'd3 || fetch_count !== 32'd9)
      $display("FAIL fault_counts got %0d/%0d exp 3/9", stall_count, fetch_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    snap_t e, g;
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL async_reset got %h exp %h", g, e); else n_pass++;
    n_checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0)
      $display("FAIL async_reset_counters got %0d/%0d exp 0/0", fetch_count, stall_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_range_fault();
    snap_t e, g;
    int errs = 0;
    for (int k = 1; k <= 256; k++) begin
      exp_q.push_back(mk(32'(4 * k), 32'h2000_0000 + 32'(k - 1), 32'(4 * k), 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); g = snap();
      if (g !== e) begin
        if (errs < 4) $display("FAIL range_seq%0d got %h exp %h", k, g, e);
        errs++;
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL range_seq_total got %0d bad edges exp 0", errs); else n_pass++;
    exp_q.push_back(mk(32'h400, 32'd0, 32'd0, 1'b0, 1'b1));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL range_trap got %h exp %h", g, e); else n_pass++;
    n_checks++;
    if (fetch_count !== 32'd256) $display("FAIL range_fetch_count got %0d exp 256", fetch_count); else n_pass++;
    test_async_reset();
    exp_q.push_back(mk(32'd4, 32'h2000_0000, 32'd4, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front(); g = snap();
    n_checks++;
    if (g !== e) $display("FAIL restart got %h exp %h", g, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_misaligned_fault();
    test_async_reset();
    test_range_fault();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
